// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// in-order writeback stage and the multi-cycle unit (MDU) result return.
// Writeback normally wins. A starvation counter force-grants the MDU after
// STARVE_LIMIT lost contested cycles. A 32-entry scoreboard tracks GPRs that
// are still waiting for an MDU result, so decode can stall on hazards.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        ws_valid,
  input  logic        ws_we,
  input  logic [4:0]  ws_dest,
  input  logic [31:0] ws_wdata,
  input  logic [31:0] ws_pc,
  output logic        ws_ready,

  input  logic        mdu_wb_valid,
  input  logic [4:0]  mdu_wb_dest,
  input  logic [31:0] mdu_wb_data,
  input  logic [31:0] mdu_wb_pc,
  output logic        mdu_wb_ready,

  input  logic        iss_valid,
  input  logic [4:0]  iss_dest,
  output logic        iss_ready,

  output logic [31:0] busy_vec,

  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,

  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_cnt_next;
  logic [31:0] busy;
  logic [31:0] busy_next;

  logic        force_mdu;
  logic        gnt_ws;
  logic        gnt_mdu;
  logic        iss_fire;
  logic        waw_bypass;

  logic        port_we;
  logic [4:0]  port_addr;
  logic [31:0] port_data;
  logic [31:0] port_pc;

  // Grant decision: writeback wins unless the MDU has been starved long
  // enough; everything is held off while reset is asserted so all
  // handshakes read 0 during reset.
  always_comb begin
    force_mdu  = (starve_cnt == LIMIT);
    gnt_ws     = resetn && ws_valid && !(mdu_wb_valid && force_mdu);
    gnt_mdu    = resetn && mdu_wb_valid && !gnt_ws;
    waw_bypass = gnt_mdu && (mdu_wb_dest == iss_dest);
    iss_ready  = resetn && ((iss_dest == 5'd0) || !busy[iss_dest] || waw_bypass);
    iss_fire   = iss_valid && iss_ready;
    ws_ready   = resetn && (!ws_valid || gnt_ws);
    mdu_wb_ready = gnt_mdu;
  end

  // Write-port mux: the granted source drives address, data and PC; a
  // writeback with ws_we low still owns the cycle so the trace stays ordered.
  always_comb begin
    port_we   = 1'b0;
    port_addr = 5'd0;
    port_data = 32'd0;
    port_pc   = 32'd0;
    if (gnt_ws) begin
      port_we   = ws_we && (ws_dest != 5'd0);
      port_addr = ws_dest;
      port_data = ws_wdata;
      port_pc   = ws_pc;
    end else if (gnt_mdu) begin
      port_we   = (mdu_wb_dest != 5'd0);
      port_addr = mdu_wb_dest;
      port_data = mdu_wb_data;
      port_pc   = mdu_wb_pc;
    end
  end

  assign rf_we             = port_we;
  assign rf_waddr          = port_addr;
  assign rf_wdata          = port_data;
  assign debug_wb_pc       = port_pc;
  assign debug_wb_rf_we    = {4{port_we}};
  assign debug_wb_rf_wnum  = port_addr;
  assign debug_wb_rf_wdata = port_data;
  assign busy_vec          = busy;

  // Starvation count: counts contested cycles the MDU lost, saturating at
  // the limit, and restarts once the MDU is served or has nothing pending.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!mdu_wb_valid || gnt_mdu) begin
      starve_cnt_next = 4'd0;
    end else if (gnt_ws && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  // Scoreboard update: the MDU release is applied first and the new issue
  // second, so a same-index set and clear leaves the bit set; r0 never sets.
  always_comb begin
    busy_next = busy;
    if (gnt_mdu) begin
      busy_next[mdu_wb_dest] = 1'b0;
    end
    if (iss_fire && (iss_dest != 5'd0)) begin
      busy_next[iss_dest] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  // Scoreboard register; reset drops all pending bits along with the MDU.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus a randomized run, all checked
// against a behavioural model of who owns the write port and which GPRs
// still wait on the MDU.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_wdata, ws_pc;
  logic        ws_ready;
  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_dest;
  logic [31:0] mdu_wb_data, mdu_wb_pc;
  logic        mdu_wb_ready;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        iss_ready;
  logic [31:0] busy_vec;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: set of GPRs awaiting the MDU, and how many contested
  // cycles in a row the MDU has lost.
  bit [31:0] mBusy;
  int        mLost;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_we(ws_we), .ws_dest(ws_dest),
    .ws_wdata(ws_wdata), .ws_pc(ws_pc), .ws_ready(ws_ready),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_dest(mdu_wb_dest),
    .mdu_wb_data(mdu_wb_data), .mdu_wb_pc(mdu_wb_pc),
    .mdu_wb_ready(mdu_wb_ready),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .busy_vec(busy_vec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic wv, input logic we, input logic [4:0] wd,
    input logic [31:0] wdat, input logic [31:0] wpc,
    input logic mv, input logic [4:0] md,
    input logic [31:0] mdat, input logic [31:0] mpc,
    input logic iv, input logic [4:0] id);
    ws_valid = wv; ws_we = we; ws_dest = wd; ws_wdata = wdat; ws_pc = wpc;
    mdu_wb_valid = mv; mdu_wb_dest = md; mdu_wb_data = mdat; mdu_wb_pc = mpc;
    iss_valid = iv; iss_dest = id;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Who owns the port this cycle, according to the model.
  function automatic bit modelWsWins();
    bit mduStarved;
    mduStarved = mdu_wb_valid && (mLost >= LIMIT);
    return resetn && ws_valid && !mduStarved;
  endfunction

  function automatic bit modelMduWins();
    return resetn && mdu_wb_valid && !modelWsWins();
  endfunction

  function automatic bit modelIssueOk();
    if (!resetn) return 1'b0;
    if (iss_dest == 0) return 1'b1;
    if (!mBusy[iss_dest]) return 1'b1;
    return modelMduWins() && (mdu_wb_dest == iss_dest);
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic modelCheck();
    bit wsWin, mduWin;
    logic        eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData, ePc;
    wsWin  = modelWsWins();
    mduWin = modelMduWins();
    eWe = 0; eAddr = 0; eData = 0; ePc = 0;
    if (wsWin) begin
      eWe = ws_we && ws_dest != 0; eAddr = ws_dest; eData = ws_wdata; ePc = ws_pc;
    end else if (mduWin) begin
      eWe = mdu_wb_dest != 0; eAddr = mdu_wb_dest; eData = mdu_wb_data; ePc = mdu_wb_pc;
    end
    checkOutput("ws_ready", 32'(ws_ready), 32'(resetn && (!ws_valid || wsWin)));
    checkOutput("mdu_wb_ready", 32'(mdu_wb_ready), 32'(mduWin));
    checkOutput("iss_ready", 32'(iss_ready), 32'(modelIssueOk()));
    checkOutput("busy_vec", busy_vec, mBusy);
    checkOutput("rf_we", 32'(rf_we), 32'(eWe));
    checkOutput("rf_waddr", 32'(rf_waddr), 32'(eAddr));
    checkOutput("rf_wdata", rf_wdata, eData);
    checkOutput("debug_wb_pc", debug_wb_pc, ePc);
    checkOutput("debug_wb_rf_we", 32'(debug_wb_rf_we), eWe ? 32'hf : 32'h0);
    checkOutput("debug_wb_rf_wnum", 32'(debug_wb_rf_wnum), 32'(eAddr));
    checkOutput("debug_wb_rf_wdata", debug_wb_rf_wdata, eData);
  endtask

  // Move to the middle of the cycle and check.
  task automatic settle();
    #4;
    modelCheck();
  endtask

  // Clock edge: advance the model with the inputs present at the edge.
  task automatic advance();
    bit wsWin, mduWin, issOk;
    @(posedge clk);
    if (!resetn) begin
      mBusy = 0;
      mLost = 0;
    end else begin
      wsWin  = modelWsWins();
      mduWin = modelMduWins();
      issOk  = modelIssueOk();
      if (mdu_wb_valid && wsWin) mLost = (mLost + 1 > LIMIT) ? LIMIT : mLost + 1;
      else mLost = 0;
      if (mduWin) mBusy[mdu_wb_dest] = 1'b0;
      if (iss_valid && issOk && iss_dest != 0) mBusy[iss_dest] = 1'b1;
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    applyStimulus(1, 1, 5'd3, 32'hdead, 32'h100, 1, 5'd4, 32'hbeef, 32'h200, 1, 5'd6);
    mBusy = 0;
    mLost = 0;
    @(posedge clk);
    #1;

    // Reset held with every valid high: all outputs read 0.
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput("rst_ws_ready", 32'(ws_ready), 0);
      checkOutput("rst_iss_ready", 32'(iss_ready), 0);
      checkOutput("rst_rf_we", 32'(rf_we), 0);
      advance();
    end
    idle();
    resetn = 1'b1;
    settle();
    checkOutput("post_rst_busy", busy_vec, 0);
    advance();

    // Writeback only.
    applyStimulus(1, 1, 5'd5, 32'h1234, 32'h1c000000, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("ws_rf_we", 32'(rf_we), 1);
    checkOutput("ws_waddr", 32'(rf_waddr), 5);
    checkOutput("ws_wdata", rf_wdata, 32'h1234);
    checkOutput("ws_dbg_we", 32'(debug_wb_rf_we), 32'hf);
    checkOutput("ws_dbg_pc", debug_wb_pc, 32'h1c000000);
    advance();
    applyStimulus(1, 1, 5'd0, 32'h1234, 32'h1c000004, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("ws_r0_rf_we", 32'(rf_we), 0);
    checkOutput("ws_r0_ready", 32'(ws_ready), 1);
    advance();

    // Starvation: MDU loses four contested cycles, wins the fifth.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 1, 5'd2, 32'(c), 32'h1c000100 + 32'(c), 1, 5'd7, 32'h77, 32'h1c000200, 0, 0);
      settle();
      checkOutput("starve_ws_ready", 32'(ws_ready), (c == 4) ? 0 : 1);
      checkOutput("starve_mdu_ready", 32'(mdu_wb_ready), (c == 4) ? 1 : 0);
      if (c == 4) checkOutput("starve_waddr", 32'(rf_waddr), 7);
      advance();
    end
    idle();

    // Scoreboard: issue, hazard, WAW bypass, release.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    settle();
    checkOutput("sb_iss1_ready", 32'(iss_ready), 1);
    advance();
    settle();
    checkOutput("sb_busy_set", busy_vec, 32'h200);
    checkOutput("sb_iss2_ready", 32'(iss_ready), 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd9, 32'h99, 32'h1c000300, 1, 5'd9);
    settle();
    checkOutput("sb_waw_ready", 32'(iss_ready), 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd9, 32'h98, 32'h1c000304, 0, 0);
    settle();
    checkOutput("sb_waw_busy", busy_vec, 32'h200);
    advance();
    idle();
    settle();
    checkOutput("sb_cleared", busy_vec, 0);
    advance();

    // r0 handling.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
    settle();
    checkOutput("r0_iss_ready", 32'(iss_ready), 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd0, 32'h55, 32'h1c000400, 0, 0);
    settle();
    checkOutput("r0_busy", busy_vec, 0);
    checkOutput("r0_mdu_ready", 32'(mdu_wb_ready), 1);
    checkOutput("r0_rf_we", 32'(rf_we), 0);
    advance();

    // Build busy = 0x300 and three lost contested cycles, then reset.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
    settle(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    settle(); advance();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 5'd1, 32'h11, 32'h1c000500, 1, 5'd20, 32'h22, 32'h1c000600, 0, 0);
      settle(); advance();
    end
    checkOutput("pre_rst_busy", busy_vec, 32'h300);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy_vec, 0);
    mBusy = 0;
    mLost = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 1, 5'd1, 32'h33, 32'h1c000700, 1, 5'd20, 32'h44, 32'h1c000800, 0, 0);
      settle();
      checkOutput("rst_starve_mdu_ready", 32'(mdu_wb_ready), (c == 4) ? 1 : 0);
      advance();
    end

    // Randomized traffic with a narrow register range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                    $urandom, $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)));
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
